// File: rtl/clk_div_pkg.sv
// Shared constants and divisor helper for the multi-channel clock divider.
// calc_div turns a target output frequency into a half-period divisor D.
package clk_div_pkg;

    localparam int CNT_W_DEF       = 24;
    localparam int DEFAULT_DIV_DEF = 1;

    // D = round(sys_hz / (2 * tgt_hz)), never below 1
    function automatic int unsigned calc_div(input int unsigned sys_hz,
                                             input int unsigned tgt_hz);
        int unsigned d;
        d = 1;
        if (tgt_hz != 0) begin
            d = (sys_hz + tgt_hz) / (2 * tgt_hz);
            if (d == 0) d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/clk_divider_mc_if.sv
// Divisor write port shared between the register master and the divider.
// One write per cycle; no backpressure, the divider always accepts.
interface clk_divider_mc_if
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              i_wr_en;
    logic [CH_W-1:0]   i_wr_ch;
    logic [CNT_W-1:0]  i_wr_data;

    modport master (output i_wr_en, output i_wr_ch, output i_wr_data);
    modport slave  (input  i_wr_en, input  i_wr_ch, input  i_wr_data);

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/staged divisor, toggle and tick strobe.
// Registered outputs; a staged divisor only takes over at a half-period boundary.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena_i,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_data_i,
    output logic             clk_o,
    output logic             tick_o,
    output logic             applied_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             applied_q, applied_d;

    logic [CNT_W-1:0] div_m1;
    logic             terminal;
    logic             have_new;
    logic [CNT_W-1:0] new_div;

    // A zero divisor behaves exactly like one
    assign div_m1   = (div_q == '0) ? '0 : div_q - CNT_W'(1);
    assign terminal = (cnt_q == div_m1);
    // A write landing on the apply edge bypasses the staging register
    assign have_new = wr_en_i | pend_vld_q;
    assign new_div  = wr_en_i ? wr_data_i : pend_q;

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        clk_d      = clk_q;
        tick_d     = 1'b0;
        applied_d  = 1'b0;
        pend_d     = wr_en_i ? wr_data_i : pend_q;
        pend_vld_d = pend_vld_q | wr_en_i;

        if (sync_i || !en_i) begin
            cnt_d = '0;
            clk_d = 1'b0;
            if (have_new) begin
                div_d      = new_div;
                pend_vld_d = 1'b0;
                applied_d  = 1'b1;
            end
        end else if (ena_i) begin
            if (terminal) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = 1'b1;
                if (have_new) begin
                    div_d      = new_div;
                    pend_vld_d = 1'b0;
                    applied_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            div_q      <= CNT_W'(DEFAULT_DIV);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            clk_q      <= 1'b0;
            tick_q     <= 1'b0;
            applied_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            clk_q      <= clk_d;
            tick_q     <= tick_d;
            applied_q  <= applied_d;
        end
    end

    assign clk_o     = clk_q;
    assign tick_o    = tick_q;
    assign applied_o = applied_q;

endmodule

// File: rtl/clk_divider_mc.sv
// Multi-channel programmable clock divider: write decode plus NUM_CH channels.
// Outputs registered (one cycle); writes are never back-pressured.
module clk_divider_mc
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic              i_clkPin,
    input  logic              i_rst_n,
    input  logic              i_ena,
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic              i_sync,
    clk_divider_mc_if.slave   wr_if,
    output logic [NUM_CH-1:0] o_clkPin,
    output logic [NUM_CH-1:0] o_tick,
    output logic [NUM_CH-1:0] o_applied
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] wr_hit;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        // Channel numbers at or above NUM_CH match no channel and are dropped
        assign wr_hit[k] = wr_if.i_wr_en && (wr_if.i_wr_ch == CH_W'(k));

        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk       (i_clkPin),
            .rst_n     (i_rst_n),
            .ena_i     (i_ena),
            .en_i      (i_ch_en[k]),
            .sync_i    (i_sync),
            .wr_en_i   (wr_hit[k]),
            .wr_data_i (wr_if.i_wr_data),
            .clk_o     (o_clkPin[k]),
            .tick_o    (o_tick[k]),
            .applied_o (o_applied[k])
        );
    end

endmodule

// File: tb/tb_clk_divider_mc.sv
// Directed bench for clk_divider_mc: three channels, 8-bit divisors, DEFAULT_DIV=3.
module tb_clk_divider_mc;
    import clk_div_pkg::*;

    localparam int NCH = 3;
    localparam int CW  = 8;
    localparam int DD  = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic           sync;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] clk_o, tick_o, applied_o;

    int n_tests = 0;
    int n_fail  = 0;

    clk_divider_mc_if #(.NUM_CH(NCH), .CNT_W(CW)) wr_if ();

    clk_divider_mc #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DD)) dut (
        .i_clkPin  (clk),
        .i_rst_n   (rst_n),
        .i_ena     (ena),
        .i_ch_en   (ch_en),
        .i_sync    (sync),
        .wr_if     (wr_if),
        .o_clkPin  (clk_o),
        .o_tick    (tick_o),
        .o_applied (applied_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_tests++;
        if (got !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int d);
        wr_if.i_wr_en   = 1'b1;
        wr_if.i_wr_ch   = 2'(ch);
        wr_if.i_wr_data = 8'(d);
    endtask

    task automatic wr_off();
        wr_if.i_wr_en   = 1'b0;
        wr_if.i_wr_ch   = '0;
        wr_if.i_wr_data = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b1;
        sync  = 1'b0;
        ch_en = '1;
        wr_off();
        repeat (2) step();
        check("rst_clk", clk_o, 0);
        check("rst_tick", tick_o, 0);
        check("rst_applied", applied_o, 0);

        // 1: default divisor 3, all channels in lock-step
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("t1_clk", clk_o, ((k / 3) % 2) ? 7 : 0);
            check("t1_tick", tick_o, (k % 3 == 0) ? 7 : 0);
        end

        // 2: ch1 at D=4, restage to 2 mid-period, then D=5 on a terminal edge
        wr(1, 4); sync = 1'b1;
        step();
        sync = 1'b0; wr_off();
        check("t2_sync_applied", applied_o, 2);
        check("t2_sync_clk", clk_o, 0);
        wr(1, 9); step();
        wr(1, 2); step();
        wr_off();
        check("t2_e2_applied", applied_o[1], 0);
        check("t2_e2_clk", clk_o[1], 0);
        step(); check("t2_e3_clk", clk_o[1], 0);
        step();
        check("t2_e4_clk", clk_o[1], 1);
        check("t2_e4_applied", applied_o[1], 1);
        check("t2_e4_tick", tick_o[1], 1);
        step();
        check("t2_e5_applied", applied_o[1], 0);
        check("t2_e5_clk", clk_o[1], 1);
        step();
        check("t2_e6_clk", clk_o[1], 0);
        check("t2_e6_tick", tick_o[1], 1);
        step(); step();
        check("t2_e8_clk", clk_o[1], 1);
        step();
        wr(1, int'(calc_div(100, 10)));
        step();
        wr_off();
        check("t2_e10_clk", clk_o[1], 0);
        check("t2_e10_applied", applied_o[1], 1);
        repeat (4) step();
        check("t2_e14_clk", clk_o[1], 0);
        step();
        check("t2_e15_clk", clk_o[1], 1);
        check("t2_e15_tick", tick_o[1], 1);

        // 3: D=0 on ch0 acts as 1, D=7 on ch2
        sync = 1'b1; wr(0, 0);
        step();
        check("t3_applied0", applied_o, 1);
        wr(2, 7);
        step();
        check("t3_applied2", applied_o, 4);
        sync = 1'b0; wr_off();
        for (int k = 1; k <= 14; k++) begin
            step();
            check("t3_clk0", clk_o[0], k & 1);
            check("t3_tick0", tick_o[0], 1);
            check("t3_clk2", clk_o[2], (k / 7) % 2);
            check("t3_tick2", tick_o[2], (k % 7 == 0) ? 1 : 0);
        end

        // 4: global enable low for 10 cycles mid-period
        repeat (3) step();
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("t4_hold_clk", clk_o & 3'b101, 1);
            check("t4_hold_tick", tick_o, 0);
            check("t4_hold_applied", applied_o, 0);
        end
        ena = 1'b1;
        step();
        check("t4_resume_clk0", clk_o[0], 0);
        check("t4_resume_clk2", clk_o[2], 0);
        repeat (2) step();
        check("t4_pre_clk2", clk_o[2], 0);
        step();
        check("t4_term_clk2", clk_o[2], 1);
        check("t4_term_tick2", tick_o[2], 1);

        // 5: ch0 D=3, ch1 D=5, out of phase, then aligned by a sync pulse
        wr(0, 3); step(); wr_off();
        check("t5_applied0", applied_o[0], 1);
        repeat (4) step();
        sync = 1'b1; step(); sync = 1'b0;
        check("t5_sync_clk", clk_o, 0);
        check("t5_sync_tick", tick_o, 0);
        for (int k = 1; k <= 15; k++) begin
            step();
            check("t5_clk0", clk_o[0], (k / 3) % 2);
            check("t5_clk1", clk_o[1], (k / 5) % 2);
        end

        // Channel disable applies a staged divisor at once
        wr(1, 2); step(); wr_off();
        check("ce_staged", applied_o[1], 0);
        ch_en = 3'b101; step();
        check("ce_off_clk", clk_o[1], 0);
        check("ce_off_applied", applied_o[1], 1);
        ch_en = 3'b111; step();
        check("ce_re1_clk", clk_o[1], 0);
        step();
        check("ce_re2_clk", clk_o[1], 1);

        // Out-of-range channel write is dropped
        wr(3, 1); step(); wr_off();
        check("bad_ch_applied", applied_o, 0);
        sync = 1'b1; step(); sync = 1'b0;
        check("bad_ch_sync_applied", applied_o, 0);
        check("bad_ch_sync_clk", clk_o, 0);

        // 6: async reset with a staged write outstanding
        repeat (4) step();
        wr(2, 9); step(); wr_off();
        check("t6_pre_clk", clk_o, 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_clk", clk_o, 0);
        check("t6_rst_tick", tick_o, 0);
        check("t6_rst_applied", applied_o, 0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t6_clk", clk_o, ((k / 3) % 2) ? 7 : 0);
            check("t6_applied", applied_o, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
